// File: rtl/field_pkg.sv
// Shared constants and types for the curve25519 field datapath.
// Reused by the result serializer and the input-side deserializer.
package field_pkg;

  localparam int FIELD_W      = 255;
  localparam int FIELD_NBYTES = 32;

  localparam logic [254:0] P25519 =
    255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_SEND   = 2'd2
  } state_e;

endpackage

// File: rtl/canon_reduce.sv
// Combinational canonicalisation: subtracts p once when the value is >= p.
// Inputs are always below 2^255 < 2p, so a single subtraction is enough.
module canon_reduce
  import field_pkg::*;
#(
  parameter int W = 256
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] P_EXT = W'(P25519);

  always_comb begin
    result = value;
    if (value >= P_EXT) result = value - P_EXT;
  end

endmodule

// File: rtl/res_byte_serializer.sv
// Captures one engine result over a four-phase ack, optionally reduces it mod p,
// and streams it out little-endian, one byte per tx handshake.
module res_byte_serializer
  import field_pkg::*;
#(
  parameter int N      = FIELD_W,
  parameter int NBYTES = FIELD_NBYTES,
  parameter bit CANON  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         res_valid,
  input  logic [N-1:0] res_data,
  output logic         res_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic         done,
  output state_e       fsm_state
);

  localparam int SW = NBYTES * 8;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  // tx handshake: a byte moves on a posedge where tx_valid and tx_ready are
  // both high; while tx_valid is high and tx_ready low, tx_data/tx_last hold.
  state_e         state_q, state_d;
  logic [SW-1:0]  shreg_q, shreg_d, reduced;
  logic [IW-1:0]  idx_q, idx_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           capture;
  logic           at_last;

  canon_reduce #(.W(SW)) u_reduce (
    .value  (shreg_q),
    .result (reduced)
  );

  assign capture = (state_q == S_IDLE) && res_valid && !ready_q;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    // Ack runs on its own: raised at capture, released once the engine lets go.
    if (capture) ready_d = 1'b1;
    else if (ready_q && !res_valid) ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          shreg_d = SW'(res_data);
          state_d = CANON ? S_REDUCE : S_SEND;
        end
      end
      S_REDUCE: begin
        shreg_d = reduced;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          shreg_d = shreg_q >> 8;
          if (at_last) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid  = (state_q == S_SEND);
  assign tx_data   = shreg_q[7:0];
  assign tx_last   = tx_valid && at_last;
  assign busy      = (state_q != S_IDLE);
  assign res_ready = ready_q;
  assign done      = done_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_res_byte_serializer.sv
// Bench for res_byte_serializer: a canonicalising and a raw instance share all
// inputs; each byte stream is checked against a queue filled at drive time.
module tb_res_byte_serializer;
  import field_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               res_valid = 1'b0;
  logic [254:0]       res_data = '0;
  logic               tx_ready = 1'b1;
  logic [1:0]         res_ready, tx_valid, tx_last, busy, done_s;
  logic [1:0][7:0]    tx_data;
  state_e             st0, st1;

  logic [8:0] exp_q[$];
  logic [8:0] raw_q[$];

  int checks = 0;
  int errors = 0;
  int xfer_cnt0 = 0;

  always #5 clk = ~clk;

  res_byte_serializer #(.N(255), .NBYTES(32), .CANON(1'b1)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready), .tx_last(tx_last[0]), .busy(busy[0]), .done(done_s[0]),
    .fsm_state(st0)
  );

  res_byte_serializer #(.N(255), .NBYTES(32), .CANON(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready), .tx_last(tx_last[1]), .busy(busy[1]), .done(done_s[1]),
    .fsm_state(st1)
  );

  // Output monitor: byte scoreboard, stall stability, done pulse timing.
  logic       prev_stall [2];
  logic [9:0] prev_word  [2];
  logic       last_xfer  [2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_stall[i] = 1'b0; prev_word[i] = '0; last_xfer[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        prev_stall[i] = 1'b0;
        last_xfer[i]  = 1'b0;
      end else begin
        checks++;
        assert (done_s[i] === last_xfer[i]) else begin
          errors++; $error("FAIL done%0d got %b exp %b", i, done_s[i], last_xfer[i]);
        end
        if (prev_stall[i]) begin
          checks++;
          assert ({tx_valid[i], tx_last[i], tx_data[i]} === prev_word[i]) else begin
            errors++; $error("FAIL stall%0d got %h exp %h", i,
                             {tx_valid[i], tx_last[i], tx_data[i]}, prev_word[i]);
          end
        end
        last_xfer[i] = 1'b0;
        if (tx_valid[i] && tx_ready) begin
          int qs;
          logic [8:0] e;
          qs = (i == 0) ? exp_q.size() : raw_q.size();
          checks++;
          assert (qs != 0) else begin
            errors++; $error("FAIL extra_byte%0d got %h exp none", i, tx_data[i]);
          end
          if (qs != 0) begin
            e = (i == 0) ? exp_q.pop_front() : raw_q.pop_front();
            checks++;
            assert ({tx_last[i], tx_data[i]} === e) else begin
              errors++; $error("FAIL byte%0d got %h exp %h", i, {tx_last[i], tx_data[i]}, e);
            end
          end
          if (tx_last[i]) begin
            checks++;
            assert (tx_data[i][7] === 1'b0) else begin
              errors++; $error("FAIL top_bit%0d got %b exp 0", i, tx_data[i][7]);
            end
            last_xfer[i] = 1'b1;
          end
          if (i == 0) xfer_cnt0++;
        end
        prev_stall[i] = tx_valid[i] && !tx_ready;
        prev_word[i]  = {tx_valid[i], tx_last[i], tx_data[i]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input logic [254:0] v);
    logic [255:0] raw, red, p_ext;
    p_ext = {1'b0, P25519};
    raw   = {1'b0, v};
    red   = (raw >= p_ext) ? raw - p_ext : raw;
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back({(k == 31), red[8*k +: 8]});
      raw_q.push_back({(k == 31), raw[8*k +: 8]});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_tx_last"},   32'(tx_last),   32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done_s),    32'd0);
    check({tag, "_state"},     32'(st0),       32'(S_IDLE));
  endtask

  // Raise res_valid, wait for both acks, optionally keep holding, then drop.
  task automatic offer(input logic [254:0] v, input int hold);
    int n;
    res_data  = v;
    res_valid = 1'b1;
    push_expect(v);
    n = 0;
    while (res_ready !== 2'b11 && n < 200) begin
      tick(); n++;
    end
    check("ack_timeout", 32'(n < 200), 32'd1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("ack_held", 32'(res_ready), 32'd3);
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit stall_pat);
    int n;
    int ph;
    n = 0; ph = 0;
    while ((busy !== 2'b00 || exp_q.size() != 0 || raw_q.size() != 0) && n < 3000) begin
      if (stall_pat) tx_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
      tick(); n++;
    end
    tx_ready = 1'b1;
    check("idle_timeout", 32'(n < 3000), 32'd1);
    tick();
  endtask

  initial begin
    logic [255:0] seq_v;
    int base;
    int n;

    rst = 1'b0;
    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b1;
    tick();

    // Value 1: ack and latency timing checked cycle by cycle.
    res_data  = 255'd1;
    res_valid = 1'b1;
    push_expect(255'd1);
    tick();
    check("ack_rise", 32'(res_ready), 32'd3);
    check("lat_canon_not_yet", 32'(tx_valid[0]), 32'd0);
    check("lat_raw_first", 32'(tx_valid[1]), 32'd1);
    check("busy_after_capture", 32'(busy), 32'd3);
    check("state_reduce", 32'(st0), 32'(S_REDUCE));
    res_valid = 1'b0;
    tick();
    check("ack_fall", 32'(res_ready), 32'd0);
    check("lat_canon_first", 32'(tx_valid[0]), 32'd1);
    check("first_byte", 32'(tx_data[0]), 32'h01);
    wait_idle(1'b0);

    // p itself, 2^255-1, and p-1.
    offer(P25519, 0);
    wait_idle(1'b0);
    offer({255{1'b1}}, 0);
    wait_idle(1'b0);
    offer(P25519 - 255'd1, 0);
    wait_idle(1'b0);

    // Byte k = k+1 with tx_ready pattern 1,0,0,1.
    for (int k = 0; k < 32; k++) seq_v[8*k +: 8] = 8'(k + 1);
    offer(seq_v[254:0], 0);
    wait_idle(1'b1);

    // res_valid held long after ack, then a second pulse during the stream.
    offer(255'h1234_5678_9abc_def0, 10);
    tick();
    offer({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 31'($urandom)}, 0);
    wait_idle(1'b0);

    // Reset after byte 5, then a fresh full stream.
    base = xfer_cnt0;
    offer({8{$urandom}}, 0);
    n = 0;
    while (xfer_cnt0 < base + 5 && n < 200) begin
      tick(); n++;
    end
    check("byte5_timeout", 32'(n < 200), 32'd1);
    rst = 1'b0;
    tick();
    check_reset_state("mid_reset");
    exp_q.delete();
    raw_q.delete();
    rst = 1'b1;
    tick();
    offer(P25519 + 255'd5, 0);
    wait_idle(1'b0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("raw_q_empty", 32'(raw_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/res_byte_serializer.md
Name: res_byte_serializer

Overview:
- Consumer end of the engine result handshake (res_valid/res_ready), as used by scalarmultB, multmod and point_add outputs.
- Captures one 255-bit field element, optionally reduces it to canonical form mod p = 2^255-19, and emits it as a 32-byte little-endian stream (RFC 7748 u-coordinate encoding) on a valid/ready byte interface.
- Sits between an arithmetic engine's result port and the host/UART/bus byte path.

Parameters:
- N, 255, field element width.
- NBYTES, 32, output bytes per element; must equal ceil((N+1)/8).
- CANON, 1, 1 = conditional subtract p before sending; 0 = send raw value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- res_valid  in  1  engine result valid; held by engine until it sees res_ready.
- res_data  in  N  engine result value (px or Z output).
- res_ready  out  1  acknowledge to engine; four-phase.
- tx_data  out  8  output byte.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  downstream accepts byte.
- tx_last  out  1  high with byte NBYTES-1.
- busy  out  1  element held or being sent.
- done  out  1  one-cycle pulse after the last byte transfers.

Behaviour:
- Reset (rst==0 at posedge): state IDLE, res_ready=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, done=0, byte index=0, shift register=0. Reset mid-stream abandons the element; no partial-stream completion.
- Transfer on tx when tx_valid&tx_ready at posedge. Result capture on res_valid&!res_ready in IDLE.
- Ack (four-phase, independent of send):
  - At capture, res_ready<=1.
  - res_ready stays 1 until a posedge with res_valid==0, then res_ready<=0.
  - No new capture while res_ready==1 or state!=IDLE.
- FSM:
  - IDLE: on capture latch {1'b0,res_data} (256 b) into shift register; busy<=1. Next state REDUCE if CANON else SEND.
  - REDUCE (1 cycle): if value >= p, value <= value - p (single subtraction suffices, since value < 2^255 < 2p). Then SEND.
  - SEND: tx_valid=1, tx_data=reg[7:0], tx_last=(idx==NBYTES-1).
    - On transfer: shift register right by 8, idx+1.
    - On transfer with tx_last: tx_valid<=0, idx<=0, done<=1 for one cycle, busy<=0, state IDLE.
- AXI-style stability: tx_data/tx_valid/tx_last stay constant while tx_valid&!tx_ready.
- Latency, capture edge to first tx_valid: 2 cycles (CANON=1) or 1 cycle (CANON=0).
- Minimum element period: NBYTES + 2 cycles at tx_ready=1.
- Byte 31 bit 7 is always 0.
- res_valid rising in the same cycle as the final byte transfer is not captured until the next cycle (state IDLE first).
- res_data is sampled only at capture; later changes are ignored.

Decomposition:
- Shared package field_pkg: P25519 constant (255'd57896044618658097711785492504343953926634992332820282019728792003956564819949), field width 255, byte count 32.
- One sub-module: canon_reduce (combinational compare-and-subtract of 256-bit value against p, output reduced value). It is reused later by the input-side deserializer.

Test Plan:
- res_data=1, tx_ready=1 -> bytes 01,00×31; tx_last on the 32nd byte; done pulse one cycle later; res_ready rises the cycle after capture and falls the cycle after res_valid drops.
- res_data=P25519, CANON=1 -> 32 bytes 00. Same stimulus with CANON=0 -> ED,FF×30,7F.
- res_data=2^255-1, CANON=1 -> 12,00×31. res_data=2^255-20 (p-1) -> EC,FF×30,7F, unreduced.
- tx_ready pattern 1,0,0,1 repeated with res_data=0x0102..20 (byte k = k+1) -> stream 01..20 in order; tx_data stable while stalled; no byte lost or duplicated.
- res_valid held high 10 cycles after res_ready -> exactly one element is sent; second res_valid pulse after the drop -> second element sent after done.
- rst=0 for one cycle after byte 5 of a stream -> all outputs return to reset values; next res_valid produces a full fresh 32-byte stream.
